fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- PC generator and prefetch buffer that sits directly upstream of the 17-bit instruction memory.
- Drives the memory's 16-bit address and read-enable, then captures the returned instruction into a small FIFO tagged with its PC.
- Presents instructions to decode through a valid/ready handshake.
- Supports pipeline redirect (branch/jump/flush) from downstream.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, ≥2)
- RESET_PC, 16'h0000, PC loaded on reset
- ADDR_W, 16, PC / memory address width
- INSTR_W, 17, instruction width

Ports:
- clk  input  1  system clock; the memory samples on negedge, this block on posedge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  redirect request from downstream
- flush_pc  input  ADDR_W  redirect target
- im_addr  output  ADDR_W  address to instruction memory (= current PC)
- im_rd_en  output  1  read enable to instruction memory
- im_instr  input  INSTR_W  instruction from memory, valid after the negedge of a cycle with im_rd_en=1
- if_valid  output  1  head entry valid
- if_instr  output  INSTR_W  head instruction
- if_pc  output  ADDR_W  PC of head instruction
- if_ready  input  1  decode accepts head this cycle
- fifo_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - pc=RESET_PC; count=0; rd/wr pointers=0; entry storage cleared to 0.
  - Outputs: if_valid=0, if_instr=0, if_pc=0, fifo_count=0.
  - im_rd_en=0 while rst=1; im_addr=pc.
- Issue (combinational):
  - pop = if_valid & if_ready.
  - im_rd_en = !rst & !flush & ((count<DEPTH) | pop).
  - im_addr = pc, always.
- Capture: the memory updates im_instr on the negedge of the issue cycle. On the following posedge, if im_rd_en was 1:
  - write {im_instr, pc} into FIFO at wr_ptr;
  - wr_ptr++ (wraps mod DEPTH);
  - pc <= pc+1, with 16-bit wrap FFFF→0000.
  - Fetch-to-visible latency: an instruction issued in cycle t appears at the head, if empty, with if_valid=1 in cycle t+1.
- Pop: on posedge with pop=1, rd_ptr++ (wrap).
  - Head outputs are driven combinationally from storage[rd_ptr].
  - if_valid = (count!=0).
- Count:
  - push only: count+1; pop only: count−1; both or neither: unchanged.
  - count never exceeds DEPTH and never underflows.
- Full with simultaneous pop: push and pop in the same cycle are allowed; count stays at DEPTH.
- Empty: if_valid=0; if_ready is ignored and no pop occurs.
- Flush, taking priority over issue/push/pop:
  - While flush=1, im_rd_en=0.
  - At that posedge: pc <= flush_pc; count, rd_ptr and wr_ptr <= 0.
  - Any head handshake in the flush cycle is discarded; decode owns that redirect.
  - Next cycle: im_addr=flush_pc, im_rd_en=1.
  - Back-to-back flushes: last target wins.
- Reset mid-operation: same as flush, but pc <= RESET_PC and storage is cleared. rst has priority over flush.
- Stale memory output: im_instr is never sampled in cycles with im_rd_en=0. The memory holds its last value; that value must not be pushed.

Test Plan:
- Reset then free-run, if_ready=1:
  - im_addr steps 0,1,2,… one per cycle.
  - if_pc trails im_addr by one cycle; if_instr = mem[if_pc]; fifo_count stays 1.
- if_ready=0 from reset:
  - exactly 4 issues (addr 0–3) occur, then im_rd_en=0 and fifo_count=4 with im_addr=4 held.
  - Raise if_ready: pops 0,1,2,3 in order, with issue resuming same cycle at addr 4.
- Full, pulse if_ready for 1 cycle:
  - that cycle has im_rd_en=1 (addr 4); fifo_count stays 4.
  - Head advances to pc=1; the entry for pc=4 appears at the tail.
- Flush with flush_pc=16'h0100 while 3 entries queued:
  - next cycle fifo_count=0, if_valid=0, im_addr=0100.
  - First delivered instruction has if_pc=0100 = mem[0100]; no pre-flush PC is ever delivered.
- Start with flush_pc=16'hFFFE and if_ready=1: delivered if_pc sequence is FFFE, FFFF, 0000, 0001.
- Assert rst for 1 cycle with 2 entries queued:
  - im_rd_en=0 during rst; afterwards fifo_count=0, if_valid=0.
  - Fetch restarts at RESET_PC. rst and flush in the same cycle → pc=RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generator and prefetch FIFO feeding decode from instruction memory
// Issues one fetch per cycle while space exists; returned words are tagged with their PC.
module fetch_queue #(
  parameter int                 DEPTH    = 4,
  parameter int                 ADDR_W   = 16,
  parameter int                 INSTR_W  = 17,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        flush_pc,
  output logic [ADDR_W-1:0]        im_addr,
  output logic                     im_rd_en,
  input  logic [INSTR_W-1:0]       im_instr,
  output logic                     if_valid,
  output logic [INSTR_W-1:0]       if_instr,
  output logic [ADDR_W-1:0]        if_pc,
  input  logic                     if_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ADDR_W-1:0]  r_pc;
  logic [CW-1:0]      r_count;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      r_wr_ptr;
  logic [INSTR_W-1:0] r_instr_q [DEPTH];
  logic [ADDR_W-1:0]  r_pc_q    [DEPTH];

  logic w_pop;
  logic w_push;
  logic w_has_space;

  assign if_valid    = (r_count != '0);
  assign if_instr    = r_instr_q[r_rd_ptr];
  assign if_pc       = r_pc_q[r_rd_ptr];
  assign fifo_count  = r_count;

  assign w_pop       = if_valid & if_ready;
  assign w_has_space = (r_count < FULL_CNT);

  // A pop frees the slot the returning word will land in, so issue may proceed when full.
  assign im_rd_en    = !rst & !flush & (w_has_space | w_pop);
  assign im_addr     = r_pc;
  assign w_push      = im_rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_q[i] <= '0;
        r_pc_q[i]    <= '0;
      end
    end else if (flush) begin
      // Entries are abandoned by resetting the pointers; storage contents are don't-care.
      r_pc     <= flush_pc;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_instr_q[r_wr_ptr] <= im_instr;
        r_pc_q[r_wr_ptr]    <= r_pc;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
        r_pc                <= r_pc + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed vector bench for fetch_queue with a negedge memory model
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] flush_pc;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [16:0] im_instr;
  logic        if_valid;
  logic [16:0] if_instr;
  logic [15:0] if_pc;
  logic        if_ready;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  int cur_row = 0;

  fetch_queue dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .im_addr    (im_addr),
    .im_rd_en   (im_rd_en),
    .im_instr   (im_instr),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_ready   (if_ready),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] mem_fn(input logic [15:0] a);
    return {~a[0], a ^ 16'h3C5A};
  endfunction

  // Memory updates only on the negedge of an issue cycle; otherwise it holds its last word.
  initial im_instr = 17'h0;
  always @(negedge clk) begin
    if (im_rd_en === 1'b1) im_instr = mem_fn(im_addr);
  end

  typedef struct {
    logic        rst;
    logic        flush;
    logic [15:0] fpc;
    logic        rdy;
    logic [15:0] e_addr;
    logic        e_en;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
    logic        chk_head;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic [15:0] fpc, input logic rdy,
                     input logic [15:0] ea, input logic ee, input logic ev,
                     input logic [15:0] ep, input logic [2:0] ec, input logic ch);
    vec_t v;
    v.rst = r; v.flush = f; v.fpc = fpc; v.rdy = rdy;
    v.e_addr = ea; v.e_en = ee; v.e_valid = ev; v.e_pc = ep; v.e_cnt = ec; v.chk_head = ch;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, cur_row, act, exp);
    end
  endtask

  task automatic check_head(input logic ev, input logic [15:0] ep);
    check("if_pc", 32'(if_pc), 32'(ep));
    check("if_instr", 32'(if_instr), ev ? 32'(mem_fn(ep)) : 32'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = 16'h0; if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //  rst flush fpc      rdy  addr     en  vld pc       cnt chk
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 3'd0, 1); // reset state
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 3'd0, 0);
    add(0, 0, 16'h0000, 0, 16'h0001, 1, 1, 16'h0000, 3'd1, 1); // visible one cycle after issue
    add(0, 0, 16'h0000, 0, 16'h0002, 1, 1, 16'h0000, 3'd2, 1);
    add(0, 0, 16'h0000, 0, 16'h0003, 1, 1, 16'h0000, 3'd3, 1);
    add(0, 0, 16'h0000, 0, 16'h0004, 0, 1, 16'h0000, 3'd4, 1); // full, issue stops
    add(0, 0, 16'h0000, 0, 16'h0004, 0, 1, 16'h0000, 3'd4, 1);
    add(0, 0, 16'h0000, 1, 16'h0004, 1, 1, 16'h0000, 3'd4, 1); // one-cycle pop while full
    add(0, 0, 16'h0000, 0, 16'h0005, 0, 1, 16'h0001, 3'd4, 1);
    add(0, 0, 16'h0000, 1, 16'h0005, 1, 1, 16'h0001, 3'd4, 1);
    add(0, 0, 16'h0000, 1, 16'h0006, 1, 1, 16'h0002, 3'd4, 1);
    add(0, 0, 16'h0000, 1, 16'h0007, 1, 1, 16'h0003, 3'd4, 1);
    add(0, 0, 16'h0000, 1, 16'h0008, 1, 1, 16'h0004, 3'd4, 1); // pc=4 entry reached head
    add(0, 1, 16'h0100, 1, 16'h0009, 0, 1, 16'h0005, 3'd4, 1); // flush, pop discarded
    add(0, 0, 16'h0000, 0, 16'h0100, 1, 0, 16'h0000, 3'd0, 0);
    add(0, 0, 16'h0000, 0, 16'h0101, 1, 1, 16'h0100, 3'd1, 1);
    add(0, 0, 16'h0000, 0, 16'h0102, 1, 1, 16'h0100, 3'd2, 1);
    add(0, 1, 16'hFFFE, 0, 16'h0103, 0, 1, 16'h0100, 3'd3, 1); // flush with 3 queued
    add(0, 0, 16'h0000, 1, 16'hFFFE, 1, 0, 16'h0000, 3'd0, 0);
    add(0, 0, 16'h0000, 1, 16'hFFFF, 1, 1, 16'hFFFE, 3'd1, 1);
    add(0, 0, 16'h0000, 1, 16'h0000, 1, 1, 16'hFFFF, 3'd1, 1); // pc wraps
    add(0, 0, 16'h0000, 1, 16'h0001, 1, 1, 16'h0000, 3'd1, 1);
    add(0, 0, 16'h0000, 0, 16'h0002, 1, 1, 16'h0001, 3'd1, 1);
    add(1, 0, 16'h0000, 0, 16'h0003, 0, 1, 16'h0001, 3'd2, 1); // rst with 2 queued
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 3'd0, 1); // storage cleared
    add(1, 1, 16'h0200, 0, 16'h0001, 0, 1, 16'h0000, 3'd1, 1); // rst beats flush
    add(0, 0, 16'h0000, 1, 16'h0000, 1, 0, 16'h0000, 3'd0, 0);
    add(0, 1, 16'h0300, 1, 16'h0001, 0, 1, 16'h0000, 3'd1, 1);
    add(0, 1, 16'h0400, 1, 16'h0300, 0, 0, 16'h0000, 3'd0, 0); // last flush target wins
    add(0, 0, 16'h0000, 1, 16'h0400, 1, 0, 16'h0000, 3'd0, 0);
    add(0, 0, 16'h0000, 1, 16'h0401, 1, 1, 16'h0400, 3'd1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      cur_row  = i;
      rst      = vecs[i].rst;
      flush    = vecs[i].flush;
      flush_pc = vecs[i].fpc;
      if_ready = vecs[i].rdy;
      #2;
      check("im_addr", 32'(im_addr), 32'(vecs[i].e_addr));
      check("im_rd_en", 32'(im_rd_en), 32'(vecs[i].e_en));
      check("if_valid", 32'(if_valid), 32'(vecs[i].e_valid));
      check("fifo_count", 32'(fifo_count), 32'(vecs[i].e_cnt));
      if (vecs[i].chk_head) check_head(vecs[i].e_valid, vecs[i].e_pc);
      @(posedge clk);
      #1;
    end

    // Free-run from reset with decode always ready.
    cur_row  = 1000;
    rst      = 1'b1; flush = 1'b0; if_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("run_addr0", 32'(im_addr), 32'h0);
    check("run_valid0", 32'(if_valid), 32'h0);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 12; k++) begin
      cur_row = 1000 + k;
      #2;
      check("run_addr", 32'(im_addr), 32'(k));
      check("run_en", 32'(im_rd_en), 32'h1);
      check("run_count", 32'(fifo_count), 32'h1);
      check_head(1'b1, 16'(k - 1));
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
